// File: rtl/ram_dp_sr_sw_be_pkg.sv
// ram_pkg: definitions shared by the dual-port byte-enable RAM and its decoder.
//
// Contents:
//   clog2       - constant-evaluable ceiling log2, used to turn the byte count
//                 of a word into a shift amount
//   BYTES       - bytes per word for the default 64-bit word width
//   BYTE_SHIFT  - log2(BYTES) for the default word width
//   RDW_OLD     - read-during-write mode: read returns the pre-write word
//   RDW_NEW     - read-during-write mode: read returns the merged new word
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int DEFAULT_DATA_WIDTH = 64;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int BYTES      = DEFAULT_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = clog2(BYTES);

endpackage

// File: rtl/ram_dp_sr_sw_be_addr_dec.sv
// ram_addr_dec: combinational byte-address decoder for one RAM port.
//
// Ports:
//   i_addr   in   32          byte address presented on the port
//   o_hit    out  1           address is inside the window and word aligned
//   o_index  out  ADDR_WIDTH  word index inside the array (valid when o_hit)
module ram_addr_dec
  import ram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic [31:0]           i_addr,
  output logic                  o_hit,
  output logic [ADDR_WIDTH-1:0] o_index
);

  localparam int          SHIFT      = clog2(DATA_WIDTH / 8);
  localparam logic [31:0] ALIGN_MASK = (32'd1 << SHIFT) - 32'd1;

  logic [31:0] w_off;
  logic [31:0] w_word;

  assign w_off  = i_addr - BASE_ADDR;
  assign w_word = w_off >> SHIFT;

  // off < RAM_DEPTH*BYTES is the same as the word number having no bits above
  // the index field. The explicit addr >= BASE term stops an underflowed
  // offset from aliasing into the array.
  assign o_hit   = (i_addr >= BASE_ADDR)
                && (w_word[31:ADDR_WIDTH] == '0)
                && ((w_off & ALIGN_MASK) == '0);
  assign o_index = w_word[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_dp_sr_sw_be.sv
// ram_dp_sr_sw_be: synchronous RAM with one write port and one read port,
// per-byte write enables, base-address window decode, 1- or 2-cycle read
// latency and selectable read-during-write behaviour.
//
// Ports:
//   i_clk       in   1             rising-edge clock
//   i_rst_n     in   1             asynchronous active-low reset
//   i_wr_en     in   1             write request
//   i_wr_addr   in   32            write byte address
//   i_wr_data   in   DATA_WIDTH    write data
//   i_wr_be     in   DATA_WIDTH/8  byte enables, bit i covers byte i
//   o_wr_err    out  1             pulse: the previous write missed the window
//   i_rd_en     in   1             read request
//   i_rd_addr   in   32            read byte address
//   o_rd_data   out  DATA_WIDTH    read data, qualified by o_rd_valid
//   o_rd_valid  out  1             read response strobe
//   o_rd_err    out  1             response is a rejected read (data is 0)
module ram_dp_sr_sw_be
  import ram_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          RD_LATENCY = 1,
  parameter int          RDW_MODE   = RDW_OLD
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [31:0]             i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  output logic                    o_wr_err,
  input  logic                    i_rd_en,
  input  logic [31:0]             i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_err
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int SHIFT     = clog2(NBYTES);

  // Elaboration-time parameter checks.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_badLatency
    $error("ram_dp_sr_sw_be: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_badWidth
    $error("ram_dp_sr_sw_be: DATA_WIDTH must be a multiple of 8 in 8..128");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH + SHIFT > 31) begin : g_badDepth
    $error("ram_dp_sr_sw_be: address window does not fit in 32 bits");
  end
  if ((BASE_ADDR % NBYTES) != 0) begin : g_badBase
    $error("ram_dp_sr_sw_be: BASE_ADDR must be word aligned");
  end

  logic                  w_wrHit;
  logic                  w_rdHit;
  logic [ADDR_WIDTH-1:0] w_wrIndex;
  logic [ADDR_WIDTH-1:0] w_rdIndex;
  logic [DATA_WIDTH-1:0] w_rdWord;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  r_wrErr;
  logic                  r_s1Valid;
  logic                  r_s1Err;
  logic [DATA_WIDTH-1:0] r_s1Data;

  ram_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wrDec (
    .i_addr  (i_wr_addr),
    .o_hit   (w_wrHit),
    .o_index (w_wrIndex)
  );

  ram_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rdDec (
    .i_addr  (i_rd_addr),
    .o_hit   (w_rdHit),
    .o_index (w_rdIndex)
  );

  // Word seen by the read port this cycle. In new-data mode a same-cycle write
  // to the same word is merged byte by byte; earlier writes are already in the
  // array, so only the current write needs bypassing.
  always_comb begin
    w_rdWord = r_mem[w_rdIndex];
    if (RDW_MODE == RDW_NEW && i_wr_en && w_wrHit && (w_wrIndex == w_rdIndex)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_wr_be[b]) w_rdWord[8*b +: 8] = i_wr_data[8*b +: 8];
      end
    end
  end

  // Array write port. Storage is not reset; a write on an edge where reset is
  // held is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_wr_en && w_wrHit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_wr_be[b]) r_mem[w_wrIndex][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  // First read stage and write-error pulse. Data only moves on a read so the
  // output holds its last value when idle; a missed read returns zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrErr   <= 1'b0;
      r_s1Valid <= 1'b0;
      r_s1Err   <= 1'b0;
      r_s1Data  <= '0;
    end else begin
      r_wrErr   <= i_wr_en & ~w_wrHit;
      r_s1Valid <= i_rd_en;
      r_s1Err   <= i_rd_en & ~w_rdHit;
      if (i_rd_en) r_s1Data <= w_rdHit ? w_rdWord : '0;
    end
  end

  assign o_wr_err = r_wrErr;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  r_s2Valid;
    logic                  r_s2Err;
    logic [DATA_WIDTH-1:0] r_s2Data;

    // Extra output register stage; advances every cycle, no back-pressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s2Valid <= 1'b0;
        r_s2Err   <= 1'b0;
        r_s2Data  <= '0;
      end else begin
        r_s2Valid <= r_s1Valid;
        r_s2Err   <= r_s1Err;
        if (r_s1Valid) r_s2Data <= r_s1Data;
      end
    end

    assign o_rd_valid = r_s2Valid;
    assign o_rd_err   = r_s2Err;
    assign o_rd_data  = r_s2Data;
  end else begin : g_lat1
    assign o_rd_valid = r_s1Valid;
    assign o_rd_err   = r_s1Err;
    assign o_rd_data  = r_s1Data;
  end

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// Testbench for ram_dp_sr_sw_be. Two instances share all inputs:
//   dut0: RD_LATENCY=1, RDW_MODE=0 (old data on read-during-write)
//   dut1: RD_LATENCY=2, RDW_MODE=1 (merged new data on read-during-write)
// The driver keeps a word-array reference model and queues the expected
// response of every request; a monitor per instance pops and compares when
// the instance presents a response.
module tb_ram_dp_sr_sw_be;

  localparam int          DW    = 64;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  typedef struct {
    int          due;
    logic        err;
    logic [DW-1:0] data;
  } rdExp_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          wrEn   = 1'b0;
  logic [31:0]   wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic [7:0]    wrBe   = '0;
  logic          rdEn   = 1'b0;
  logic [31:0]   rdAddr = '0;

  logic          wrErr0, rdValid0, rdErr0;
  logic [DW-1:0] rdData0;
  logic          wrErr1, rdValid1, rdErr1;
  logic [DW-1:0] rdData1;

  int nVectors     = 0;
  int nMiscompares = 0;
  int cycleCount   = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] lastData [2];

  rdExp_t rdQ0[$];
  rdExp_t rdQ1[$];
  int     wrQ0[$];
  int     wrQ1[$];

  ram_dp_sr_sw_be #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BASE_ADDR (BASE),
    .RD_LATENCY (1), .RDW_MODE (0)
  ) dut0 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_wr_en (wrEn), .i_wr_addr (wrAddr), .i_wr_data (wrData), .i_wr_be (wrBe),
    .o_wr_err (wrErr0),
    .i_rd_en (rdEn), .i_rd_addr (rdAddr),
    .o_rd_data (rdData0), .o_rd_valid (rdValid0), .o_rd_err (rdErr0)
  );

  ram_dp_sr_sw_be #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BASE_ADDR (BASE),
    .RD_LATENCY (2), .RDW_MODE (1)
  ) dut1 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_wr_en (wrEn), .i_wr_addr (wrAddr), .i_wr_data (wrData), .i_wr_be (wrBe),
    .o_wr_err (wrErr1),
    .i_rd_en (rdEn), .i_rd_addr (rdAddr),
    .o_rd_data (rdData1), .o_rd_valid (rdValid1), .o_rd_err (rdErr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkValue(input string name, input int d, input logic [63:0] act,
                            input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cycleCount, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input int d, input logic [63:0] act,
                            input logic [63:0] exp);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cycleCount, act, exp);
  endtask

  function automatic int rdSize(input int d);
    return (d == 0) ? rdQ0.size() : rdQ1.size();
  endfunction

  function automatic rdExp_t rdFront(input int d);
    return (d == 0) ? rdQ0[0] : rdQ1[0];
  endfunction

  function automatic void rdDrop(input int d);
    if (d == 0) void'(rdQ0.pop_front());
    else        void'(rdQ1.pop_front());
  endfunction

  function automatic int wrSize(input int d);
    return (d == 0) ? wrQ0.size() : wrQ1.size();
  endfunction

  function automatic int wrFront(input int d);
    return (d == 0) ? wrQ0[0] : wrQ1[0];
  endfunction

  function automatic void wrDrop(input int d);
    if (d == 0) void'(wrQ0.pop_front());
    else        void'(wrQ1.pop_front());
  endfunction

  // Reference decode from the address rules, in wide signed arithmetic so an
  // address below the base simply gives a negative offset.
  function automatic bit modelDecode(input logic [31:0] a, output int idx);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    idx = 0;
    if (off < 0 || off >= longint'(DEPTH) * 8 || (off % 8) != 0) return 1'b0;
    idx = int'(off / 8);
    return 1'b1;
  endfunction

  // Drive one cycle of requests at a negedge, queue the expected responses,
  // update the model, then advance to the next negedge.
  task automatic applyStimulus(input logic we, input logic [31:0] wa, input logic [63:0] wd,
                               input logic [7:0] be, input logic re, input logic [31:0] ra);
    int     wi, ri;
    bit     wh, rh;
    logic [63:0] oldW, newW;
    rdExp_t x;
    wrEn = we; wrAddr = wa; wrData = wd; wrBe = be;
    rdEn = re; rdAddr = ra;
    wh = modelDecode(wa, wi);
    rh = modelDecode(ra, ri);
    if (re) begin
      oldW = rh ? model[ri] : 64'd0;
      newW = oldW;
      if (we && wh && rh && wi == ri) begin
        for (int b = 0; b < 8; b++) if (be[b]) newW[8*b +: 8] = wd[8*b +: 8];
      end
      x.err  = !rh;
      x.data = oldW;
      x.due  = cycleCount + 1;
      rdQ0.push_back(x);
      x.data = newW;
      x.due  = cycleCount + 2;
      rdQ1.push_back(x);
    end
    if (we) begin
      if (wh) begin
        for (int b = 0; b < 8; b++) if (be[b]) model[wi][8*b +: 8] = wd[8*b +: 8];
      end else begin
        wrQ0.push_back(cycleCount + 1);
        wrQ1.push_back(cycleCount + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Compare one instance's outputs against the head of its queues.
  task automatic checkOutput(input int d, input logic v, input logic e,
                             input logic [63:0] dat, input logic we);
    rdExp_t x;
    if (!rst_n) begin
      lastData[d] = '0;
      return;
    end
    while (rdSize(d) > 0 && rdFront(d).due < cycleCount) begin
      x = rdFront(d);
      rdDrop(d);
      reportFail("rd_valid_missing", d, 64'(cycleCount), 64'(x.due));
    end
    if (v) begin
      if (rdSize(d) == 0) begin
        reportFail("rd_valid_spurious", d, 64'd1, 64'd0);
      end else begin
        x = rdFront(d);
        rdDrop(d);
        checkValue("rd_latency", d, 64'(cycleCount), 64'(x.due));
        checkValue("rd_err", d, 64'(e), 64'(x.err));
        checkValue("rd_data", d, dat, x.data);
      end
      lastData[d] = dat;
    end else begin
      checkValue("rd_data_hold", d, dat, lastData[d]);
    end
    while (wrSize(d) > 0 && wrFront(d) < cycleCount) begin
      reportFail("wr_err_missing", d, 64'(cycleCount), 64'(wrFront(d)));
      wrDrop(d);
    end
    if (we) begin
      if (wrSize(d) == 0) reportFail("wr_err_spurious", d, 64'd1, 64'd0);
      else begin
        checkValue("wr_err_cycle", d, 64'(cycleCount), 64'(wrFront(d)));
        wrDrop(d);
      end
    end
  endtask

  // Monitors sample at the negedge, half a cycle away from the active edge.
  always @(negedge clk) begin
    checkOutput(0, rdValid0, rdErr0, rdData0, wrErr0);
    checkOutput(1, rdValid1, rdErr1, rdData1, wrErr1);
  end

  function automatic logic [31:0] genAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0: return BASE - 32'(8 * (1 + $urandom_range(0, 3)));
      1: return BASE + 32'(DEPTH * 8) + 32'(8 * $urandom_range(0, 3));
      2: return BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(1, 7));
      3: return BASE + 32'(8 * (DEPTH - 1 - $urandom_range(0, 3)));
      default: return BASE + 32'(8 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [31:0] wa, ra;
    lastData[0] = '0;
    lastData[1] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkValue("reset_rd_valid", 0, 64'(rdValid0), 64'd0);
    checkValue("reset_rd_err",   0, 64'(rdErr0),   64'd0);
    checkValue("reset_rd_data",  0, rdData0,       64'd0);
    checkValue("reset_wr_err",   0, 64'(wrErr0),   64'd0);
    checkValue("reset_rd_valid", 1, 64'(rdValid1), 64'd0);
    checkValue("reset_rd_err",   1, 64'(rdErr1),   64'd0);
    checkValue("reset_rd_data",  1, rdData1,       64'd0);
    checkValue("reset_wr_err",   1, 64'(wrErr1),   64'd0);
    #1 rst_n = 1'b1;

    // Give every word a known value so the model covers the whole array.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 1'b0, '0);

    // Basic write then read.
    applyStimulus(1'b1, 32'h1000, 64'h1122334455667788, 8'hFF, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1000);

    // Partial byte enables.
    applyStimulus(1'b1, 32'h1008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, '0);
    applyStimulus(1'b1, 32'h1008, 64'h0, 8'h0F, 1'b0, '0);
    applyStimulus(1'b1, 32'h1008, 64'h0123456789ABCDEF, 8'h00, 1'b1, 32'h1008);

    // Read during write to the same word.
    applyStimulus(1'b1, 32'h1010, 64'hA, 8'hFF, 1'b0, '0);
    applyStimulus(1'b1, 32'h1010, 64'hB, 8'hFF, 1'b1, 32'h1010);
    applyStimulus(1'b1, 32'h1010, 64'h0, 8'hFF, 1'b0, '0);
    applyStimulus(1'b1, 32'h1010, 64'h00000000000000FF, 8'h01, 1'b1, 32'h1010);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1010);

    // Out-of-window accesses, then readback of the words near the base.
    applyStimulus(1'b1, 32'h0FF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0, '0);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, '0, '0, 1'b1, BASE + 32'(8 * i));
    applyStimulus(1'b0, '0, '0, '0, 1'b1, BASE + 32'(DEPTH * 8));
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1004);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, BASE + 32'(8 * (DEPTH - 1)));

    // Back-to-back reads on consecutive cycles.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1000 + 32'(8 * i));
    idleCycles(3);

    // Short reset pulse with a read in flight: it must never complete.
    rdEn = 1'b1; rdAddr = 32'h1000; wrEn = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    rdEn = 1'b0;
    #5 rst_n = 1'b1;
    @(negedge clk);
    idleCycles(2);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1000);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h1008);

    // Randomized traffic concentrated on a few words to provoke collisions.
    for (int n = 0; n < 1500; n++) begin
      wa = genAddr();
      ra = ($urandom_range(0, 9) < 4) ? wa : genAddr();
      applyStimulus($urandom_range(0, 3) != 0, wa, {$urandom, $urandom},
                    8'($urandom), $urandom_range(0, 3) != 0, ra);
    end

    idleCycles(4);
    while (rdQ0.size() > 0) begin
      reportFail("rd_never_returned", 0, 64'd0, 64'(rdQ0[0].due));
      void'(rdQ0.pop_front());
    end
    while (rdQ1.size() > 0) begin
      reportFail("rd_never_returned", 1, 64'd0, 64'(rdQ1[0].due));
      void'(rdQ1.pop_front());
    end
    while (wrQ0.size() > 0) begin
      reportFail("wr_err_never_seen", 0, 64'd0, 64'(wrQ0[0]));
      void'(wrQ0.pop_front());
    end
    while (wrQ1.size() > 0) begin
      reportFail("wr_err_never_seen", 1, 64'd0, 64'(wrQ1[0]));
      void'(wrQ1.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Bound on total run time in case the stimulus ever stalls.
  initial begin
    #1000000;
    reportFail("watchdog_timeout", 0, 64'(cycleCount), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
